marchc_engine: RTL and testbench



---
 rtl/mbist_pkg.sv | 57 +++++
 rtl/marchc_addr_gen.sv | 39 +++
 rtl/marchc_engine.sv | 187 ++++++++++++++++++
 tb/tb_marchc_engine.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// mbist_pkg: shared encodings for the March C- engine.
// Holds the FSM state encoding, element indices E0..E5, and the per-element
// op count, read/write pattern, address direction and data background.
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } elem_e;

  // Background selectors; replicated to the data width at the point of use.
  localparam logic BG_D0 = 1'b0;
  localparam logic BG_D1 = 1'b1;

  // Index of the last op of an element (0 for one-op elements, 1 for two-op).
  function automatic logic elem_last_op(elem_e e);
    case (e)
      E1, E2, E3, E4: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  // Descending elements walk the address space from the top down.
  function automatic logic elem_desc(elem_e e);
    return (e == E3) || (e == E4);
  endfunction

  // Every two-op element is (read, write); E0 is a lone write, E5 a lone read.
  function automatic logic op_is_write(elem_e e, logic op);
    case (e)
      E0:      return 1'b1;
      E5:      return 1'b0;
      default: return op;
    endcase
  endfunction

  // Background used by an op: write data for writes, expected data for reads.
  function automatic logic op_bg(elem_e e, logic op);
    case (e)
      E1, E3:  return op ? BG_D1 : BG_D0;
      E2, E4:  return op ? BG_D0 : BG_D1;
      default: return BG_D0;
    endcase
  endfunction

endpackage

// File: rtl/marchc_addr_gen.sv
// marchc_addr_gen: up/down address counter for the March C- engine.
// load_i sets the start address for the given direction, adv_i steps one
// address in that direction, last_o flags the terminal address (no wrap).
module marchc_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              load_desc_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic              dir_q;

  // Address and direction register; load takes priority over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      dir_q  <= 1'b0;
    end else if (load_i) begin
      addr_q <= load_desc_i ? '1 : '0;
      dir_q  <= load_desc_i;
    end else if (adv_i) begin
      addr_q <= dir_q ? addr_q - 1'b1 : addr_q + 1'b1;
    end
  end

  // Terminal address depends on the direction latched at load time.
  always_comb begin
    last_o = dir_q ? (addr_q == '0) : (addr_q == '1);
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/marchc_engine.sv
// marchc_engine: March C- sequencer and read comparator for one SRAM.
// Optional build macro: MARCHC_FAIL_LOG_EN (first-failure address/data log).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no ops; waits for marchc_en, clears fail/log when starting
//   ST_RUN   | issues one op per cycle, E0..E5
//   ST_DRAIN | last read in flight; its compare lands here
//   ST_DONE  | marchc_complete high until marchc_en drops
module marchc_engine
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              marchc_en,
  output logic              marchc_complete,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act
);

  state_e            state_q, state_d;
  elem_e             elem_q, elem_d;
  logic              op_q, op_d;
  logic              ag_load, ag_load_desc, ag_adv, ag_last;
  logic              issue, start;
  logic              we_d, re_d;
  logic [DATA_W-1:0] wdata_d, rexp_d;
  logic              we_q, re_q;
  logic [DATA_W-1:0] wdata_q, rexp_q;
  logic              chk_q;
  logic [DATA_W-1:0] chk_exp_q;
  logic              fail_q;
  logic              mismatch;

  marchc_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ag_load),
    .load_desc_i (ag_load_desc),
    .adv_i       (ag_adv),
    .addr_o      (mem_addr),
    .last_o      (ag_last)
  );

  // State and op-position registers; (elem_q, op_q, address) is the op on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      elem_q  <= E0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
    end
  end

  // Next state and next op position; the op chosen here is issued at this edge.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    op_d         = op_q;
    ag_load      = 1'b0;
    ag_load_desc = 1'b0;
    ag_adv       = 1'b0;
    issue        = 1'b0;
    start        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (marchc_en) begin
          state_d = ST_RUN;
          elem_d  = E0;
          op_d    = 1'b0;
          ag_load = 1'b1;
          issue   = 1'b1;
          start   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!marchc_en) begin
          state_d = ST_IDLE;
        end else if (op_q != elem_last_op(elem_q)) begin
          op_d  = 1'b1;
          issue = 1'b1;
        end else if (!ag_last) begin
          op_d   = 1'b0;
          ag_adv = 1'b1;
          issue  = 1'b1;
        end else if (elem_q == E5) begin
          state_d = ST_DRAIN;
        end else begin
          elem_d       = elem_e'(elem_q + 3'd1);
          op_d         = 1'b0;
          ag_load      = 1'b1;
          ag_load_desc = elem_desc(elem_d);
          issue        = 1'b1;
        end
      end
      ST_DRAIN: state_d = marchc_en ? ST_DONE : ST_IDLE;
      ST_DONE:  if (!marchc_en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Op decode for the memory port and the completion level.
  always_comb begin
    we_d            = issue &&  op_is_write(elem_d, op_d);
    re_d            = issue && !op_is_write(elem_d, op_d);
    wdata_d         = {DATA_W{op_bg(elem_d, op_d)}};
    rexp_d          = {DATA_W{op_bg(elem_d, op_d)}};
    marchc_complete = (state_q == ST_DONE);
    mismatch        = chk_q && (mem_rdata != chk_exp_q);
  end

  // Memory strobes/data, expected-data pipeline and sticky fail flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      wdata_q   <= '0;
      rexp_q    <= '0;
      chk_q     <= 1'b0;
      chk_exp_q <= '0;
      fail_q    <= 1'b0;
    end else begin
      we_q      <= we_d;
      re_q      <= re_d;
      if (we_d) wdata_q <= wdata_d;
      rexp_q    <= rexp_d;
      chk_q     <= re_q;
      chk_exp_q <= rexp_q;
      if (start)         fail_q <= 1'b0;
      else if (mismatch) fail_q <= 1'b1;
    end
  end

`ifdef MARCHC_FAIL_LOG_EN
  logic [ADDR_W-1:0] chk_addr_q;
  logic [ADDR_W-1:0] log_addr_q;
  logic [DATA_W-1:0] log_exp_q, log_act_q;

  // First-failure log; later mismatches in the same run leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_addr_q <= '0;
      log_addr_q <= '0;
      log_exp_q  <= '0;
      log_act_q  <= '0;
    end else begin
      chk_addr_q <= mem_addr;
      if (start) begin
        log_addr_q <= '0;
        log_exp_q  <= '0;
        log_act_q  <= '0;
      end else if (mismatch && !fail_q) begin
        log_addr_q <= chk_addr_q;
        log_exp_q  <= chk_exp_q;
        log_act_q  <= mem_rdata;
      end
    end
  end

  assign fail_addr = log_addr_q;
  assign fail_exp  = log_exp_q;
  assign fail_act  = log_act_q;
`else
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
`endif

  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mem_wdata = wdata_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_marchc_engine.sv
// tb_marchc_engine: directed bench for marchc_engine with ADDR_W=4, DATA_W=8.
// A behavioural SRAM with an optional stuck-at-1 on bit 0 of address 5.
module tb_marchc_engine;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              marchc_en;
  logic              marchc_complete;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_exp;
  logic [DATA_W-1:0] fail_act;

  logic [DATA_W-1:0] mem [16];
  logic              fault;

  int n_tests = 0;
  int n_fail  = 0;

  marchc_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .marchc_en       (marchc_en),
    .marchc_complete (marchc_complete),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_re          (mem_re),
    .mem_rdata       (mem_rdata),
    .fail            (fail),
    .fail_addr       (fail_addr),
    .fail_exp        (fail_exp),
    .fail_act        (fail_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr] |
                             ((fault && mem_addr == 4'd5) ? 8'h01 : 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected bus op at run index i (0..159), written out from the March C- table.
  function automatic void exp_op(input int i, output logic we, output logic re,
                                 output logic [3:0] a, output logic [7:0] d);
    int j, e, k, op;
    if (i < 16) begin
      we = 1'b1; re = 1'b0; a = 4'(i); d = 8'h00;
    end else if (i < 144) begin
      j  = i - 16;
      e  = j / 32;               // 0:E1 1:E2 2:E3 3:E4
      k  = j % 32;
      op = k % 2;
      a  = (e >= 2) ? 4'(15 - k / 2) : 4'(k / 2);
      we = (op == 1);
      re = (op == 0);
      if (e % 2 == 0) d = (op == 1) ? 8'hFF : 8'h00;
      else            d = (op == 1) ? 8'h00 : 8'hFF;
    end else begin
      we = 1'b0; re = 1'b1; a = 4'(i - 144); d = 8'h00;
    end
  endfunction

  // Full run from a negedge: op order, completion timing, hold and release.
  task automatic run_full(output int fail_cyc, output logic fail_end);
    int errs;
    int comp_cyc;
    logic ewe, ere;
    logic [3:0] ea;
    logic [7:0] ed;
    errs      = 0;
    comp_cyc  = -1;
    fail_cyc  = -1;
    marchc_en = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) check("fail_clear_at_start", 32'(fail), 32'd0);
      if (c <= 160) begin
        exp_op(c - 1, ewe, ere, ea, ed);
        if (mem_we !== ewe || mem_re !== ere || mem_addr !== ea ||
            (ewe && mem_wdata !== ed)) errs++;
      end else if (mem_we || mem_re) begin
        errs++;
      end
      if (fail && fail_cyc < 0) fail_cyc = c;
      if (marchc_complete) begin
        comp_cyc = c;
        break;
      end
    end
    check("op_sequence_errors", 32'(errs), 32'd0);
    check("complete_cycle", 32'(comp_cyc), 32'd162);
    fail_end = fail;
    errs = 0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      if (!marchc_complete || mem_we || mem_re) errs++;
    end
    check("done_hold", 32'(errs), 32'd0);
    marchc_en = 1'b0;
    @(negedge clk);
    check("complete_fall", 32'(marchc_complete), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_complete"}, 32'(marchc_complete), 32'd0);
    check({tag, "_we"},       32'(mem_we),          32'd0);
    check({tag, "_re"},       32'(mem_re),          32'd0);
    check({tag, "_addr"},     32'(mem_addr),        32'd0);
    check({tag, "_wdata"},    32'(mem_wdata),       32'd0);
    check({tag, "_fail"},     32'(fail),            32'd0);
    check({tag, "_fail_log"}, {12'd0, fail_addr, fail_exp, fail_act}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fc;
    logic fe;
    rst_n     = 1'b0;
    marchc_en = 1'b0;
    fault     = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free memory.
    run_full(fc, fe);
    check("clean_fail", 32'(fe), 32'd0);
    check("clean_fail_cycle", 32'(fc), 32'hFFFF_FFFF);

    // Stuck-at-1 on bit 0 of address 5: E1 read of address 5 is cycle 27.
    fault = 1'b1;
    run_full(fc, fe);
    check("saf_fail", 32'(fe), 32'd1);
    check("saf_fail_cycle", 32'(fc), 32'd29);
`ifdef MARCHC_FAIL_LOG_EN
    check("saf_log_addr", 32'(fail_addr), 32'd5);
    check("saf_log_exp",  32'(fail_exp),  32'h00);
    check("saf_log_act",  32'(fail_act),  32'h01);
`else
    check("saf_log_tied", {12'd0, fail_addr, fail_exp, fail_act}, 32'd0);
`endif

    // Back-to-back: clean memory right after a failing run.
    fault = 1'b0;
    run_full(fc, fe);
    check("b2b_fail", 32'(fe), 32'd0);

    // Abort during E2 at address 7 (run index 62, cycle 63).
    fault     = 1'b1;
    marchc_en = 1'b1;
    for (int c = 1; c <= 63; c++) @(negedge clk);
    check("abort_pos_addr", 32'(mem_addr), 32'd7);
    check("abort_pos_re",   32'(mem_re),   32'd1);
    marchc_en = 1'b0;
    @(negedge clk);
    check("abort_we",       32'(mem_we),          32'd0);
    check("abort_re",       32'(mem_re),          32'd0);
    check("abort_complete", 32'(marchc_complete), 32'd0);
    check("abort_fail_kept", 32'(fail),           32'd1);
    @(negedge clk);
    check("abort_idle_re",  32'(mem_re), 32'd0);
    fault = 1'b0;
    run_full(fc, fe);
    check("restart_fail", 32'(fe), 32'd0);

    // Async reset during E3 (cycle 90), then a full run with en held high.
    marchc_en = 1'b1;
    for (int c = 1; c <= 90; c++) @(negedge clk);
    check("pre_reset_we", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_full(fc, fe);
    check("post_reset_fail", 32'(fe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
